// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, bus widths and
// the index-width helper.
package riscv_mem_pkg;

    localparam int unsigned BE_W   = 4;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Synchronous single-port word RAM with per-byte write enables; read data is
// registered and holds until the next read.
module dmem_bank
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = idx_width(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's valid/ready load/store port.
// Optional DMEM_RANGE_CHECK_EN faults any address with bits set above the RAM span.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W     = idx_width(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ready_q;
    logic              err_q, err_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;

    logic              accept;
    logic              access;
    logic              addr_err;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [WORD_W-1:0] cur_wdata;
    logic [BE_W-1:0]   cur_be;
    logic [WORD_W-1:0] bank_rdata;

    assign accept = req_valid && ready_q;

    // With zero wait states the access edge is the accept edge, so the live
    // request fields must feed the bank directly.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    assign addr_err = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (IDX_W + 2)) != '0);
`else
    logic unused_upper;
    assign addr_err     = (cur_addr[1:0] != 2'b00);
    assign unused_upper = |(cur_addr >> (IDX_W + 2));
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                        access  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (access) begin
            err_d = addr_err;
        end else if (state_q == ST_RESP && rsp_ready) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_IDLE);
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk   (clk),
        .en    (access),
        .we    (cur_we && !addr_err),
        .be    (cur_be),
        .idx   (cur_addr[IDX_W+1:2]),
        .wdata (cur_wdata),
        .rdata (bank_rdata)
    );

    assign req_ready = ready_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = err_q;
    // The bank's read register holds through RESP; gate it so stores, faults
    // and idle cycles present zero.
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? bank_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, randomized traffic
// against a word-array model, backpressure and mid-transaction reset sequences.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_a, reset_b, sel;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_model [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .ADDR_W(32)) u_a (
        .clk       (clk),
        .reset     (reset_a),
        .req_valid (req_valid & ~sel),
        .req_ready (a_req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (a_rsp_valid),
        .rsp_ready (rsp_ready & ~sel),
        .rsp_rdata (a_rsp_rdata),
        .rsp_err   (a_rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3), .ADDR_W(32)) u_b (
        .clk       (clk),
        .reset     (reset_b),
        .req_valid (req_valid & sel),
        .req_ready (b_req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (rsp_ready & sel),
        .rsp_rdata (b_rsp_rdata),
        .rsp_err   (b_rsp_err)
    );

    assign req_ready = sel ? b_req_ready : a_req_ready;
    assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
    assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One complete transaction; hold = cycles rsp_ready stays low once rsp_valid is up.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        rdata = '0;
        err   = 1'b0;
        lat   = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", rsp_valid, 1);
            return;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_stable", {rsp_valid, req_ready, rsp_err, rsp_rdata},
                  {1'b1, 1'b0, err, rdata});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("after_consume", {rsp_valid, req_ready, rsp_err, rsp_rdata},
              {1'b0, 1'b1, 1'b0, 32'h0});
    endtask

    // Reference: word array indexed by address modulo the RAM span, bytes merged by enable.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] exp_rdata,
                         output logic exp_err);
        int unsigned idx;
        idx       = (addr / 4) % DEPTH;
        exp_err   = (addr % 4 != 0) || (RC && (addr / (DEPTH * 4) != 0));
        exp_rdata = '0;
        if (exp_err) return;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_model[idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end else begin
            exp_rdata = mem_model[idx];
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] rd, exp_rd, a, wd;
        logic        er, exp_er;
        int          lat;

        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 32'h10,  32'h11223344, 4'h5, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDE22BE44, 1'b0};
        vecs[3]  = '{1'b0, 32'h13,  32'h0,        4'hF, 32'h0, 1'b1};
        vecs[4]  = '{1'b1, 32'h12,  32'hCAFEF00D, 4'hF, 32'h0, 1'b1};
        vecs[5]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vecs[6]  = '{1'b1, 32'h14,  32'h0BADF00D, 4'hF, 32'h0, 1'b0};
        vecs[7]  = '{1'b1, 32'h14,  32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
        vecs[8]  = '{1'b0, 32'h14,  32'h0,        4'hF, 32'h0BADF00D, 1'b0};
        vecs[9]  = '{1'b1, 32'h0,   32'h01234567, 4'hF, 32'h0, 1'b0};
        vecs[10] = '{1'b1, 32'h400, 32'hA5A5A5A5, 4'hF, 32'h0, RC};
        vecs[11] = '{1'b0, 32'h0,   32'h0,        4'hF,
                     RC ? 32'h01234567 : 32'hA5A5A5A5, 1'b0};

        sel = 1'b0;
        reset_a = 1'b0;
        reset_b = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_be = '0;
        rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1 check("in_reset", {a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_rdata}, 64'h0);
        @(negedge clk);
        reset_a = 1'b1;
        reset_b = 1'b1;
        @(negedge clk);
        check("after_reset", {req_ready, rsp_valid, rsp_err, rsp_rdata},
              {1'b1, 1'b0, 1'b0, 32'h0});

        // Idle rsp_ready must not disturb anything.
        rsp_ready = 1'b1;
        @(negedge clk);
        check("idle_rsp_ready", {req_ready, rsp_valid}, 2'b10);
        rsp_ready = 1'b0;

        for (int i = 0; i < 12; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 0, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
            check($sformatf("vec%0d_latency", i), lat, 2);
        end

        for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom;
            model(1'b1, i * 4, wd, 4'hF, exp_rd, exp_er);
            txn(1'b1, i * 4, wd, 4'hF, 0, rd, er, lat);
        end

        for (int n = 0; n < 150; n++) begin
            int r;
            logic w;
            logic [3:0] be;
            r  = $urandom_range(0, 9);
            a  = {22'h0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
            if (r == 7) a[1:0] = 2'($urandom_range(1, 3));
            if (r >= 8) a[31:10] = 22'($urandom_range(1, 32'h3FFFFF));
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            model(w, a, wd, be, exp_rd, exp_er);
            txn(w, a, wd, be, $urandom_range(0, 2), rd, er, lat);
            check($sformatf("rand%0d_rdata a=%h", n, a), rd, exp_rd);
            check($sformatf("rand%0d_err a=%h", n, a), er, exp_er);
            check($sformatf("rand%0d_latency", n), lat, 2);
        end

        // Backpressure: rsp_ready held low five cycles on a load of 0x10.
        model(1'b0, 32'h10, 32'h0, 4'hF, exp_rd, exp_er);
        txn(1'b0, 32'h10, 32'h0, 4'hF, 5, rd, er, lat);
        check("bp_rdata", rd, exp_rd);
        check("bp_err", er, 1'b0);

        // Mid-transaction reset on the three-wait-state instance.
        sel = 1'b1;
        txn(1'b1, 32'h20, 32'h55AA55AA, 4'hF, 0, rd, er, lat);
        check("b_store_latency", lat, 4);
        check("b_store_err", er, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hFFFFFFFF;
        req_be    = 4'hF;
        check("b_ready_before_abort", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset_b = 1'b0;
        #1 check("b_abort_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata}, 64'h0);
        @(negedge clk);
        reset_b = 1'b1;
        txn(1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat);
        check("b_abort_word_kept", rd, 32'h55AA55AA);
        check("b_load_latency", lat, 4);
        check("b_load_err", er, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule
